// File: rtl/alu_resp_checker.sv
// Response checker for the 4-bit ALU: recomputes the golden result, compares it with
// the observed response over a two-stage pipeline, and keeps run statistics and a verdict.
module alu_resp_checker #(
    parameter int CNT_W  = 8,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        sel,
    input  logic [DATA_W-1:0] out,
    input  logic              carry,
    output logic              chk_valid,
    output logic              chk_ok,
    output logic [CNT_W-1:0]  pass_count,
    output logic [CNT_W-1:0]  fail_count,
    output logic              error,
    output logic [3*DATA_W+DATA_W+4-1:0] fail_info,
    output logic              busy,
    output logic              done,
    output logic              pass
);

    localparam int INFO_W = 3 + 4 * DATA_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Run-control state machine; start overrides everything, including stop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (start) begin
            state_next = ST_RUN;
        end else begin
            case (state_reg)
                ST_IDLE:  state_next = ST_IDLE;
                ST_RUN:   state_next = stop ? ST_DRAIN : ST_RUN;
                ST_DRAIN: state_next = ST_DONE;
                ST_DONE:  state_next = ST_DONE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    logic accept;
    assign accept = (state_reg == ST_RUN) && in_valid && !start;

    // Golden model in DATA_W+1 bit arithmetic; the top bit is carry or borrow.
    logic [DATA_W:0]   sum_ext;
    logic [DATA_W:0]   diff_ext;
    logic [DATA_W-1:0] and_v;
    logic [DATA_W-1:0] or_v;
    logic [DATA_W-1:0] xor_v;
    logic [DATA_W-1:0] gold_out;
    logic              gold_carry;

    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_bitwise
            assign and_v[gi] = a[gi] & b[gi];
            assign or_v[gi]  = a[gi] | b[gi];
            assign xor_v[gi] = a[gi] ^ b[gi];
        end
    endgenerate

    always_comb begin
        gold_out   = '0;
        gold_carry = 1'b0;
        case (sel)
            3'b000: {gold_carry, gold_out} = sum_ext;
            3'b001: {gold_carry, gold_out} = diff_ext;
            3'b010: gold_out = and_v;
            3'b011: gold_out = or_v;
            3'b100: gold_out = xor_v;
            default: begin
                gold_out   = '0;
                gold_carry = 1'b0;
            end
        endcase
    end

    // Stage 1: captured transaction plus its golden result.
    logic              s1_valid_reg;
    logic [2:0]        s1_sel_reg;
    logic [DATA_W-1:0] s1_a_reg;
    logic [DATA_W-1:0] s1_b_reg;
    logic [DATA_W-1:0] s1_out_reg;
    logic              s1_carry_reg;
    logic [DATA_W-1:0] s1_exp_out_reg;
    logic              s1_exp_carry_reg;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            s1_valid_reg     <= 1'b0;
            s1_sel_reg       <= '0;
            s1_a_reg         <= '0;
            s1_b_reg         <= '0;
            s1_out_reg       <= '0;
            s1_carry_reg     <= 1'b0;
            s1_exp_out_reg   <= '0;
            s1_exp_carry_reg <= 1'b0;
        end else begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_sel_reg       <= sel;
                s1_a_reg         <= a;
                s1_b_reg         <= b;
                s1_out_reg       <= out;
                s1_carry_reg     <= carry;
                s1_exp_out_reg   <= gold_out;
                s1_exp_carry_reg <= gold_carry;
            end
        end
    end

    logic              mismatch;
    logic [INFO_W-1:0] info_next;
    logic [CNT_W-1:0]  pass_cnt_next;
    logic [CNT_W-1:0]  fail_cnt_next;

    assign mismatch  = (s1_out_reg != s1_exp_out_reg) || (s1_carry_reg != s1_exp_carry_reg);
    assign info_next = {s1_sel_reg, s1_a_reg, s1_b_reg, s1_out_reg, s1_carry_reg, s1_exp_out_reg};

    // Saturating counters: hold at all-ones instead of wrapping.
    logic [CNT_W-1:0] pass_cnt_reg;
    logic [CNT_W-1:0] fail_cnt_reg;

    assign pass_cnt_next = (pass_cnt_reg == CNT_MAX) ? pass_cnt_reg : pass_cnt_reg + CNT_W'(1);
    assign fail_cnt_next = (fail_cnt_reg == CNT_MAX) ? fail_cnt_reg : fail_cnt_reg + CNT_W'(1);

    // Stage 2: compare, statistics and first-failure capture.
    logic              chk_valid_reg;
    logic              chk_ok_reg;
    logic              error_reg;
    logic [INFO_W-1:0] fail_info_reg;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            chk_valid_reg <= 1'b0;
            chk_ok_reg    <= 1'b0;
            pass_cnt_reg  <= '0;
            fail_cnt_reg  <= '0;
            error_reg     <= 1'b0;
            fail_info_reg <= '0;
        end else begin
            chk_valid_reg <= s1_valid_reg;
            chk_ok_reg    <= s1_valid_reg && !mismatch;
            if (s1_valid_reg) begin
                if (mismatch) begin
                    fail_cnt_reg <= fail_cnt_next;
                    error_reg    <= 1'b1;
                    if (!error_reg) begin
                        fail_info_reg <= info_next;
                    end
                end else begin
                    pass_cnt_reg <= pass_cnt_next;
                end
            end
        end
    end

    assign chk_valid  = chk_valid_reg;
    assign chk_ok     = chk_ok_reg;
    assign pass_count = pass_cnt_reg;
    assign fail_count = fail_cnt_reg;
    assign error      = error_reg;
    assign fail_info  = fail_info_reg;
    assign busy       = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    assign done       = (state_reg == ST_DONE);
    assign pass       = done && (fail_cnt_reg == '0) && (pass_cnt_reg != '0);

endmodule
